// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the memory transfer request arbiter: state
// encoding, transfer direction codes and default field widths.
package mem_xfer_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int LEN_W_DEF    = 8;
    localparam int TOUT_CYC_DEF = 1023;

    // State encoding of the arbiter FSM.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ISSUE = ISSUE,
        ST_DONE  = DONE
    } xfer_state_t;

    // Direction code carried on mem_mr_xfer_wr_rd.
    localparam logic XFER_WR = 1'b1;
    localparam logic XFER_RD = 1'b0;

    // Timeout counter width: enough to hold TOUT_CYC, never narrower than one bit.
    function automatic int cnt_width(input int tout_cyc);
        if (tout_cyc < 1) begin
            return 1;
        end else begin
            return $clog2(tout_cyc + 1);
        end
    endfunction

endpackage

// File: rtl/mem_mr_xfer_arbiter.sv
// Round-robin arbiter between the write-control and read-control
// requesters for the single memory transfer request channel. One transfer
// is outstanding at a time; the granted requester gets a one-cycle ack,
// flagged as an error when the memory side never answered in time.
module mem_mr_xfer_arbiter #(
    parameter int ADDR_W   = mem_xfer_pkg::ADDR_W_DEF,
    parameter int LEN_W    = mem_xfer_pkg::LEN_W_DEF,
    parameter int TOUT_CYC = mem_xfer_pkg::TOUT_CYC_DEF
) (
    input  logic              mem_clk,
    input  logic              mem_rst_n,
    input  logic              wr_xfer_req,
    input  logic [ADDR_W-1:0] wr_xfer_addr,
    input  logic [LEN_W-1:0]  wr_xfer_len,
    output logic              wr_xfer_ack,
    output logic              wr_xfer_err,
    input  logic              rd_xfer_req,
    input  logic [ADDR_W-1:0] rd_xfer_addr,
    input  logic [LEN_W-1:0]  rd_xfer_len,
    output logic              rd_xfer_ack,
    output logic              rd_xfer_err,
    output logic              mem_mr_xfer_valid,
    output logic              mem_mr_xfer_wr_rd,
    output logic [ADDR_W-1:0] mem_mr_xfer_addr,
    output logic [LEN_W-1:0]  mem_mr_xfer_len,
    input  logic              mem_mr_xfer_ack,
    output logic              arb_busy
);

    import mem_xfer_pkg::*;

    localparam int              CNT_W     = cnt_width(TOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic            TOUT_EN   = (TOUT_CYC > 0) ? 1'b1 : 1'b0;
    // Last ISSUE cycle index before giving up; unused when the timeout is off.
    localparam logic [CNT_W-1:0] TOUT_LAST = (TOUT_CYC > 0) ? CNT_W'(TOUT_CYC - 1) : CNT_MAX;

    xfer_state_t       state_r,   state_s;
    logic              valid_r,   valid_s;
    logic              wr_rd_r,   wr_rd_s;
    logic [ADDR_W-1:0] addr_r,    addr_s;
    logic [LEN_W-1:0]  len_r,     len_s;
    logic              wr_ack_r,  wr_ack_s;
    logic              wr_err_r,  wr_err_s;
    logic              rd_ack_r,  rd_ack_s;
    logic              rd_err_r,  rd_err_s;
    logic              busy_r,    busy_s;
    logic [CNT_W-1:0]  cnt_r,     cnt_s;
    logic              prio_wr_r, prio_wr_s;
    logic              wr_win_s;
    logic              abort_s;
    logic              tout_hit_s;

    assign tout_hit_s = TOUT_EN & (cnt_r == TOUT_LAST);

    // Next-state, grant selection and next values of every registered output.
    always_comb begin
        state_s   = state_r;
        valid_s   = valid_r;
        wr_rd_s   = wr_rd_r;
        addr_s    = addr_r;
        len_s     = len_r;
        wr_ack_s  = 1'b0;
        wr_err_s  = 1'b0;
        rd_ack_s  = 1'b0;
        rd_err_s  = 1'b0;
        cnt_s     = cnt_r;
        prio_wr_s = prio_wr_r;
        wr_win_s  = 1'b0;
        abort_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (wr_xfer_req || rd_xfer_req) begin
                    // A lone request wins; under contention the pointer decides.
                    wr_win_s = wr_xfer_req & (~rd_xfer_req | prio_wr_r);
                    state_s  = ST_ISSUE;
                    valid_s  = 1'b1;
                    wr_rd_s  = wr_win_s ? XFER_WR : XFER_RD;
                    addr_s   = wr_win_s ? wr_xfer_addr : rd_xfer_addr;
                    len_s    = wr_win_s ? wr_xfer_len  : rd_xfer_len;
                end else begin
                    valid_s = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (mem_mr_xfer_ack || tout_hit_s) begin
                    // An ack arriving on the timeout cycle still completes cleanly.
                    abort_s = ~mem_mr_xfer_ack;
                    state_s = ST_DONE;
                    valid_s = 1'b0;
                    cnt_s   = '0;
                    if (wr_rd_r == XFER_WR) begin
                        wr_ack_s = 1'b1;
                        wr_err_s = abort_s;
                    end else begin
                        rd_ack_s = 1'b1;
                        rd_err_s = abort_s;
                    end
                end else begin
                    // Saturate rather than wrap when the timeout is disabled.
                    cnt_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
                end
            end
            ST_DONE: begin
                // Hand priority to whoever did not win this round.
                state_s   = ST_IDLE;
                valid_s   = 1'b0;
                cnt_s     = '0;
                prio_wr_s = (wr_rd_r == XFER_RD) ? 1'b1 : 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                cnt_s   = '0;
            end
        endcase

        busy_s = (state_s != ST_IDLE) ? 1'b1 : 1'b0;
    end

    // State, pointer, counter and output registers with synchronous reset.
    always_ff @(posedge mem_clk) begin
        if (!mem_rst_n) begin
            state_r   <= ST_IDLE;
            valid_r   <= 1'b0;
            wr_rd_r   <= 1'b0;
            addr_r    <= '0;
            len_r     <= '0;
            wr_ack_r  <= 1'b0;
            wr_err_r  <= 1'b0;
            rd_ack_r  <= 1'b0;
            rd_err_r  <= 1'b0;
            busy_r    <= 1'b0;
            cnt_r     <= '0;
            prio_wr_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            valid_r   <= valid_s;
            wr_rd_r   <= wr_rd_s;
            addr_r    <= addr_s;
            len_r     <= len_s;
            wr_ack_r  <= wr_ack_s;
            wr_err_r  <= wr_err_s;
            rd_ack_r  <= rd_ack_s;
            rd_err_r  <= rd_err_s;
            busy_r    <= busy_s;
            cnt_r     <= cnt_s;
            prio_wr_r <= prio_wr_s;
        end
    end

    assign mem_mr_xfer_valid = valid_r;
    assign mem_mr_xfer_wr_rd = wr_rd_r;
    assign mem_mr_xfer_addr  = addr_r;
    assign mem_mr_xfer_len   = len_r;
    assign wr_xfer_ack       = wr_ack_r;
    assign wr_xfer_err       = wr_err_r;
    assign rd_xfer_ack       = rd_ack_r;
    assign rd_xfer_err       = rd_err_r;
    assign arb_busy          = busy_r;

endmodule

// File: tb/tb_mem_mr_xfer_arbiter.sv
// Bench for mem_mr_xfer_arbiter: requester agents and a memory responder
// drive the DUT, a transaction-level model predicts grant order and outcome
// into a queue, and a monitor compares each completed transfer.
module tb_mem_mr_xfer_arbiter;

    localparam int TOUT = 16;

    typedef struct packed {
        logic        wr_rd;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [15:0] dur;
        logic        err;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_v [2];
    logic [31:0] addr_v[2];
    logic [7:0]  len_v [2];
    logic        wr_xfer_ack, wr_xfer_err, rd_xfer_ack, rd_xfer_err;
    logic        valid, wr_rd, busy;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic        resp_ack, spur_ack, mem_ack;

    assign mem_ack = resp_ack | spur_ack;

    always #5 clk = ~clk;

    mem_mr_xfer_arbiter #(.ADDR_W(32), .LEN_W(8), .TOUT_CYC(TOUT)) dut (
        .mem_clk          (clk),
        .mem_rst_n        (rst_n),
        .wr_xfer_req      (req_v[1]),
        .wr_xfer_addr     (addr_v[1]),
        .wr_xfer_len      (len_v[1]),
        .wr_xfer_ack      (wr_xfer_ack),
        .wr_xfer_err      (wr_xfer_err),
        .rd_xfer_req      (req_v[0]),
        .rd_xfer_addr     (addr_v[0]),
        .rd_xfer_len      (len_v[0]),
        .rd_xfer_ack      (rd_xfer_ack),
        .rd_xfer_err      (rd_xfer_err),
        .mem_mr_xfer_valid(valid),
        .mem_mr_xfer_wr_rd(wr_rd),
        .mem_mr_xfer_addr (m_addr),
        .mem_mr_xfer_len  (m_len),
        .mem_mr_xfer_ack  (mem_ack),
        .arb_busy         (busy)
    );

    int    checks = 0;
    int    errors = 0;
    xfer_t exp_q[$];
    int    resp_q[$];
    bit    ptr_wr;           // model: which side wins the next contended round
    bit    ag_go  [2];
    bit    ag_busy[2];
    bit    ag_scr [2];
    logic [31:0] ag_addr[2];
    logic [7:0]  ag_len [2];
    bit    abort;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Expected outcome of one granted transfer, from the timeout rule.
    function automatic xfer_t model(input bit is_wr, input logic [31:0] a, input logic [7:0] l, input int d);
        xfer_t t;
        t.wr_rd = is_wr;
        t.addr  = a;
        t.len   = l;
        if (d < TOUT) begin
            t.dur = 16'(d + 1);
            t.err = 1'b0;
        end else begin
            t.dur = 16'(TOUT);
            t.err = 1'b1;
        end
        return t;
    endfunction

    // Requester agent: hold req/addr/len until own ack, drop at the edge ending it.
    task automatic agent(input int idx);
        int n;
        bit done;
        forever begin
            @(posedge clk);
            if (ag_go[idx]) begin
                #2;
                ag_go[idx]   = 1'b0;
                ag_busy[idx] = 1'b1;
                req_v[idx]   = 1'b1;
                addr_v[idx]  = ag_addr[idx];
                len_v[idx]   = ag_len[idx];
                n = 0;
                done = 1'b0;
                while (!done) begin
                    @(negedge clk);
                    n++;
                    if (abort) begin
                        done = 1'b1;
                    end else if ((idx == 1) ? wr_xfer_ack : rd_xfer_ack) begin
                        @(posedge clk);
                        #2;
                        done = 1'b1;
                    end else if (n > 200) begin
                        checks++;
                        errors++;
                        $display("FAIL agent%0d_timeout: no ack after %0d cycles, required ack", idx, n);
                        done = 1'b1;
                    end else if (ag_scr[idx] && valid && (wr_rd == (idx == 1))) begin
                        addr_v[idx] = $urandom;
                        len_v[idx]  = 8'($urandom);
                    end
                end
                req_v[idx]   = 1'b0;
                ag_busy[idx] = 1'b0;
            end
        end
    endtask

    initial agent(1);
    initial agent(0);

    // Memory responder: ack d cycles into each grant; d >= TOUT means never.
    initial begin
        int  cnt;
        int  cur_d;
        bit  prev;
        resp_ack = 1'b0;
        prev = 1'b0;
        cnt = 0;
        cur_d = 1000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp_ack = 1'b0;
                prev = 1'b0;
            end else begin
                resp_ack = 1'b0;
                if (valid && !prev) begin
                    cur_d = (resp_q.size() > 0) ? resp_q.pop_front() : 1000;
                    cnt = 0;
                end else if (valid) begin
                    cnt++;
                end
                if (valid && (cnt == cur_d)) resp_ack = 1'b1;
                prev = valid;
            end
        end
    end

    // Monitor: capture each grant, compare every requester ack against the model queue.
    initial begin
        bit          mon_prev_v;
        int          mon_dur;
        logic        cap_wr_rd;
        logic [31:0] cap_addr;
        logic [7:0]  cap_len;
        xfer_t       obs;
        xfer_t       e;
        mon_prev_v = 1'b0;
        mon_dur = 0;
        cap_wr_rd = 1'b0;
        cap_addr = 32'd0;
        cap_len = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_v = 1'b0;
                mon_dur = 0;
            end else begin
                if (wr_xfer_ack || rd_xfer_ack) begin
                    check("ack_exclusive", 64'(wr_xfer_ack & rd_xfer_ack), 64'd0);
                    check("grant_dir", 64'(cap_wr_rd), 64'(wr_xfer_ack));
                    obs.wr_rd = wr_xfer_ack;
                    obs.addr  = cap_addr;
                    obs.len   = cap_len;
                    obs.dur   = 16'(mon_dur);
                    obs.err   = wr_xfer_ack ? wr_xfer_err : rd_xfer_err;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: got ack %0h with no transfer outstanding, required none", 64'(obs));
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer", 64'(obs), 64'(e));
                        check("ack_follows_valid", 64'({mon_prev_v, valid}), 64'd2);
                    end
                end
                if (valid && !mon_prev_v) begin
                    cap_wr_rd = wr_rd;
                    cap_addr  = m_addr;
                    cap_len   = m_len;
                    mon_dur   = 1;
                end else if (valid) begin
                    mon_dur++;
                    check("stable", 64'({wr_rd, m_addr, m_len}), 64'({cap_wr_rd, cap_addr, cap_len}));
                end
                if (valid) check("busy_with_valid", 64'(busy), 64'd1);
                mon_prev_v = valid;
            end
        end
    end

    // Queue the expected grants in model order and release the agents.
    task automatic issue(input bit w, input logic [31:0] aw, input logic [7:0] lw, input int dw, input bit sw,
                         input bit r, input logic [31:0] ar, input logic [7:0] lr, input int dr, input bit sr);
        bit first_wr;
        bit cur;
        first_wr = (w && r) ? ptr_wr : w;
        for (int k = 0; k < 2; k++) begin
            cur = (k == 0) ? first_wr : !first_wr;
            if (cur && w) begin
                exp_q.push_back(model(1'b1, aw, lw, dw));
                resp_q.push_back(dw);
            end else if (!cur && r) begin
                exp_q.push_back(model(1'b0, ar, lr, dr));
                resp_q.push_back(dr);
            end
        end
        ptr_wr = (w && r) ? first_wr : !w;
        ag_addr[1] = aw; ag_len[1] = lw; ag_scr[1] = sw;
        ag_addr[0] = ar; ag_len[0] = lr; ag_scr[0] = sr;
        ag_go[1] = w;
        ag_go[0] = r;
    endtask

    task automatic finish_ep(input string tag);
        for (int i = 0; i < 400 && (ag_go[0] || ag_go[1] || ag_busy[0] || ag_busy[1] || exp_q.size() != 0); i++)
            @(negedge clk);
        check({tag, "_drain"}, 64'(exp_q.size() + int'(ag_busy[0]) + int'(ag_busy[1])), 64'd0);
    endtask

    task automatic outputs_zero(input string tag);
        check(tag, 64'({valid, wr_rd, m_addr, m_len, wr_xfer_ack, wr_xfer_err, rd_xfer_ack, rd_xfer_err, busy}), 64'd0);
    endtask

    task automatic spurious();
        @(negedge clk);
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("spur_quiet", 64'({valid, wr_xfer_ack, rd_xfer_ack}), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w, r;
        int          sel, dw, dr;
        rst_n = 1'b0;
        spur_ack = 1'b0;
        abort = 1'b0;
        ptr_wr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; addr_v[i] = 32'd0; len_v[i] = 8'd0;
            ag_go[i] = 1'b0; ag_busy[i] = 1'b0; ag_scr[i] = 1'b0;
            ag_addr[i] = 32'd0; ag_len[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        outputs_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Contention from reset: W,R then W,R.
        issue(1'b1, 32'hA000_0010, 8'd3, 2, 1'b0, 1'b1, 32'hB000_0020, 8'd5, 2, 1'b0);
        finish_ep("contend1");
        issue(1'b1, 32'hA000_0030, 8'd1, 2, 1'b0, 1'b1, 32'hB000_0040, 8'd9, 2, 1'b0);
        finish_ep("contend2");

        // Single write, checking the one-cycle grant latency.
        issue(1'b1, 32'h0000_1000, 8'd7, 4, 1'b0, 1'b0, 32'd0, 8'd0, 0, 1'b0);
        @(posedge clk); #3;
        check("valid_before_grant", 64'(valid), 64'd0);
        @(posedge clk); #1;
        check("grant_latency", 64'({valid, wr_rd, m_addr, m_len}), 64'({1'b1, 1'b1, 32'h0000_1000, 8'd7}));
        finish_ep("single_wr");

        // Read that never gets acked, then a normal write.
        issue(1'b0, 32'd0, 8'd0, 0, 1'b0, 1'b1, 32'hC000_0000, 8'd15, 40, 1'b0);
        finish_ep("rd_timeout");
        issue(1'b1, 32'h0000_2000, 8'd2, 1, 1'b0, 1'b0, 32'd0, 8'd0, 0, 1'b0);
        finish_ep("after_timeout");

        // Ack exactly on the last allowed cycle, and one cycle too late.
        issue(1'b0, 32'd0, 8'd0, 0, 1'b0, 1'b1, 32'hC000_0100, 8'd4, TOUT - 1, 1'b0);
        finish_ep("ack_at_limit");
        issue(1'b0, 32'd0, 8'd0, 0, 1'b0, 1'b1, 32'hC000_0200, 8'd4, TOUT, 1'b0);
        finish_ep("ack_too_late");

        // Spurious memory ack while idle, then inputs changing mid-transfer.
        spurious();
        issue(1'b1, 32'h0000_3000, 8'd6, 5, 1'b1, 1'b0, 32'd0, 8'd0, 0, 1'b0);
        finish_ep("scramble");

        // Reset while the read is in flight; afterwards write must win again.
        issue(1'b1, 32'hA000_0050, 8'd2, 1, 1'b0, 1'b1, 32'hB000_0060, 8'd3, 10, 1'b0);
        for (int i = 0; i < 100 && !(valid && !wr_rd); i++) @(negedge clk);
        @(negedge clk);
        check("rd_in_flight", 64'({valid, wr_rd}), 64'd2);
        abort = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        outputs_zero("reset_mid_xfer");
        repeat (2) @(negedge clk);
        exp_q.delete();
        resp_q.delete();
        ptr_wr = 1'b1;
        abort = 1'b0;
        rst_n = 1'b1;
        issue(1'b1, 32'hA000_0070, 8'd8, 1, 1'b0, 1'b1, 32'hB000_0080, 8'd4, 1, 1'b0);
        finish_ep("after_reset");

        // Randomised rounds.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(1, 3);
            w = sel[0];
            r = sel[1];
            dw = ($urandom_range(0, 3) == 0) ? $urandom_range(TOUT - 2, TOUT + 4) : $urandom_range(0, 6);
            dr = ($urandom_range(0, 3) == 0) ? $urandom_range(TOUT - 2, TOUT + 4) : $urandom_range(0, 6);
            issue(w, $urandom, 8'($urandom), dw, 1'($urandom_range(0, 1)),
                  r, $urandom, 8'($urandom), dr, 1'($urandom_range(0, 1)));
            finish_ep("random");
            if ($urandom_range(0, 3) == 0) spurious();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
